pipe_stage_reg: RTL

// - Parametrised, generalised inter-stage pipeline register; the successor to the fixed-field EX/MEM latch.
// - Sits between any two stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is driven by the shared ctrl stall vector.
// - Adds:
//   - a valid bit;
//   - a flush input with priority over stall;
//   - a generic carry field, fed back to the producing stage for multi-cycle ops (madd/msub hilo+cnt);
//   - a saturating hold counter.

---
 rtl/pipe_stage_reg.sv | 96 +++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: valid bit, flush-over-stall priority, carry-back field and saturating hold counter.
// Optional stall/bubble performance counters are built only when PIPE_STAGE_PERF_CNT_EN is defined.
module pipe_stage_reg #(
   parameter int unsigned                 PAYLOAD_W   = 64,
   parameter int unsigned                 CARRY_W     = 66,
   parameter logic [PAYLOAD_W-1:0]        NOP_PAYLOAD = '0,
   parameter int unsigned                 STALL_W     = 6,
   parameter int unsigned                 STAGE_IDX   = 3,
   parameter int unsigned                 HOLD_CNT_W  = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [STALL_W-1:0]    stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [PAYLOAD_W-1:0]  in_payload,
   input  logic [CARRY_W-1:0]    carry_i,
   output logic                  out_valid,
   output logic [PAYLOAD_W-1:0]  out_payload,
   output logic [CARRY_W-1:0]    carry_o,
   output logic [HOLD_CNT_W-1:0] hold_cnt,
   output logic [31:0]           perf_stall,
   output logic [31:0]           perf_bubble
);

   logic s_self;
   logic s_next;
   logic is_bubble;
   logic is_capture;
   logic hold_sat;
   logic unused_stall;

   assign s_self     = stall[STAGE_IDX];
   assign s_next     = stall[STAGE_IDX+1];
   assign is_bubble  = s_self & ~s_next;
   assign is_capture = ~s_self;
   assign hold_sat   = &hold_cnt;

   // Only two bits of the shared stall vector matter to this stage.
   assign unused_stall = ^stall;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid   <= 1'b0;
         out_payload <= NOP_PAYLOAD;
         carry_o     <= '0;
         hold_cnt    <= '0;
      end else if (flush) begin
         out_valid   <= 1'b0;
         out_payload <= NOP_PAYLOAD;
         carry_o     <= '0;
         hold_cnt    <= '0;
      end else if (is_bubble) begin
         out_valid   <= 1'b0;
         out_payload <= NOP_PAYLOAD;
         carry_o     <= carry_i;
         hold_cnt    <= '0;
      end else if (is_capture) begin
         out_valid   <= in_valid;
         out_payload <= in_valid ? in_payload : NOP_PAYLOAD;
         carry_o     <= '0;
         hold_cnt    <= '0;
      end else begin
         if (!hold_sat) begin
            hold_cnt <= hold_cnt + 1'b1;
         end
      end
   end

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0] perf_stall_q;
   logic [31:0] perf_bubble_q;

   // Flush cycles still count as stall cycles but never as bubbles.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_stall_q  <= '0;
         perf_bubble_q <= '0;
      end else begin
         if (s_self) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
         if (!flush && is_bubble) begin
            perf_bubble_q <= perf_bubble_q + 32'd1;
         end
      end
   end

   assign perf_stall  = perf_stall_q;
   assign perf_bubble = perf_bubble_q;
`else
   assign perf_stall  = 32'h0;
   assign perf_bubble = 32'h0;
`endif

endmodule
